// File: rtl/router_pkg.sv
// Shared definitions for the NoC router input port:
// direction encoding, flit field positions and the input FSM states.
package router_pkg;

   localparam int NumDirs = 5;
   localparam int North   = 0;
   localparam int South   = 1;
   localparam int West    = 2;
   localparam int East    = 3;
   localparam int Local   = 4;

   localparam int FlitW   = 34;
   localparam int HeadBit = FlitW - 1;
   localparam int TailBit = FlitW - 2;
   localparam int DestX   = 0;
   localparam int DestY   = 3;
   localparam int CoordW  = 3;

   typedef logic [NumDirs-1:0] route_t;
   typedef logic [CoordW-1:0]  coord_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } in_state_t;

   // Dimension-ordered route: resolve X first, then Y, else eject locally.
   function automatic route_t xy_route(
      input coord_t dx,
      input coord_t dy,
      input coord_t px,
      input coord_t py
   );
      route_t r;
      r = '0;
      if (dx > px)      r[East]  = 1'b1;
      else if (dx < px) r[West]  = 1'b1;
      else if (dy > py) r[South] = 1'b1;
      else if (dy < py) r[North] = 1'b1;
      else              r[Local] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/router_input_fifo.sv
// Synchronous flit buffer for one router input port.
// Pushes are refused when full, even if a pop happens in the same cycle.
module router_input_fifo #(
   parameter int Width = 34,
   parameter int Depth = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [Width-1:0] wdata,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(Depth);

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      count_q, count_d;
   logic [Width-1:0] mem_q [Depth];
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(Depth));
   assign empty   = (count_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem_q[rptr_q];

   // Pointer and occupancy update; pointers wrap naturally (Depth is 2^n).
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Control state, cleared asynchronously.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   // Storage array; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q] <= wdata;
   end

endmodule

// File: rtl/router_input_unit.sv
// NoC router input port: buffers flits, computes the XY route of the
// head flit and requests/forwards through the output arbiters.
module router_input_unit
   import router_pkg::*;
#(
   parameter int FlitWidth = FlitW,
   parameter int Depth     = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [2:0]           position_x,
   input  logic [2:0]           position_y,
   input  logic [FlitWidth-1:0] data_in,
   input  logic                 data_in_void,
   output logic                 stop_out,
   output logic [4:0]           request,
   input  logic [4:0]           grant,
   input  logic [4:0]           stop_in,
   output logic [FlitWidth-1:0] data_out,
   output logic                 data_out_valid,
   output logic                 forwarding_head,
   output logic                 forwarding_tail
);

   localparam int HeadIdx = FlitWidth - (FlitW - HeadBit);
   localparam int TailIdx = FlitWidth - (FlitW - TailBit);

   logic [FlitWidth-1:0] front;
   logic                 fifo_full, fifo_empty;
   logic                 push, pop, fire, discard;
   logic                 front_head, front_tail;
   route_t               route_comb, route_q, route_d, req;
   in_state_t            state_q, state_d;

   assign push = ~data_in_void;

   router_input_fifo #(
      .Width (FlitWidth),
      .Depth (Depth)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .wdata (data_in),
      .rdata (front),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign front_head = front[HeadIdx];
   assign front_tail = front[TailIdx];
   assign route_comb = xy_route(front[DestX +: CoordW],
                                front[DestY +: CoordW],
                                position_x, position_y);

   // Request source: live route for a new head, latched route mid-packet.
   always_comb begin
      req     = '0;
      discard = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               if (front_head) req = route_comb;
               else            discard = 1'b1;
            end
         end
         ACTIVE: begin
            if (!fifo_empty) req = route_q;
         end
         default: req = '0;
      endcase
   end

   assign fire            = |(req & grant & ~stop_in);
   assign pop             = fire | discard;
   assign request         = req;
   assign data_out_valid  = fire;
   assign forwarding_head = fire & front_head;
   assign forwarding_tail = fire & front_tail;
   assign data_out        = fifo_empty ? '0 : front;
   assign stop_out        = fifo_full;

   // Packet tracking: lock the route on a multi-flit head, free on tail.
   always_comb begin
      state_d = state_q;
      route_d = route_q;
      if (fire) begin
         if (state_q == IDLE && front_head && !front_tail) begin
            state_d = ACTIVE;
            route_d = route_comb;
         end else if (state_q == ACTIVE && front_tail) begin
            state_d = IDLE;
         end
      end
   end

   // Packet state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         route_q <= '0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
      end
   end

   a_req_onehot: assert property (
      @(posedge clk) disable iff (rst) $onehot0(req));

   a_grant_onehot: assert property (
      @(posedge clk) disable iff (rst) $onehot0(grant & req));

   a_no_head_active: assert property (
      @(posedge clk) disable iff (rst)
      !(state_q == ACTIVE && !fifo_empty && front_head));

   a_drop: assert property (
      @(posedge clk) disable iff (rst) !(push && fifo_full))
      else $warning("router_input_unit: flit dropped, buffer full");

   a_orphan: assert property (
      @(posedge clk) disable iff (rst) !discard)
      else $warning("router_input_unit: orphan body flit discarded");

endmodule

// File: tb/tb_router_input_unit.sv
// Vector-table bench for router_input_unit with a flit scoreboard.
// Router sits at (1,1); forwarded flits are matched in push order.
module tb_router_input_unit;

   localparam logic [4:0] R0 = 5'b00000;
   localparam logic [4:0] RN = 5'b00001;
   localparam logic [4:0] RS = 5'b00010;
   localparam logic [4:0] RE = 5'b01000;
   localparam logic [4:0] RL = 5'b10000;

   typedef struct {
      bit          off;
      logic [33:0] flit;
      bit          sb;
      logic [4:0]  g;
      logic [4:0]  s;
      logic [4:0]  er;
      bit          ev;
      bit          eh;
      bit          et;
      bit          ef;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  position_x = 3'd1;
   logic [2:0]  position_y = 3'd1;
   logic [33:0] data_in = '0;
   logic        data_in_void = 1'b1;
   logic        stop_out;
   logic [4:0]  request;
   logic [4:0]  grant = '0;
   logic [4:0]  stop_in = '0;
   logic [33:0] data_out;
   logic        data_out_valid;
   logic        forwarding_head;
   logic        forwarding_tail;

   int checks   = 0;
   int failures = 0;
   logic [33:0] sbq [$];
   vec_t tbl [35];

   router_input_unit #(.FlitWidth(34), .Depth(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .position_x      (position_x),
      .position_y      (position_y),
      .data_in         (data_in),
      .data_in_void    (data_in_void),
      .stop_out        (stop_out),
      .request         (request),
      .grant           (grant),
      .stop_in         (stop_in),
      .data_out        (data_out),
      .data_out_valid  (data_out_valid),
      .forwarding_head (forwarding_head),
      .forwarding_tail (forwarding_tail)
   );

   always #5 clk = ~clk;

   function automatic logic [33:0] fl(bit h, bit t, int dx, int dy, int pl);
      return {h, t, 26'(pl), 3'(dy), 3'(dx)};
   endfunction

   function automatic vec_t mv(bit off, logic [33:0] f, bit sb,
                               logic [4:0] g, logic [4:0] s,
                               logic [4:0] er, bit ev, bit eh,
                               bit et, bit ef);
      vec_t v;
      v.off = off; v.flit = f; v.sb = sb; v.g = g; v.s = s;
      v.er = er; v.ev = ev; v.eh = eh; v.et = et; v.ef = ef;
      return v;
   endfunction

   task automatic step(input vec_t v, input int idx);
      logic [8:0] got, exp;
      @(posedge clk);
      #1;
      data_in_void = !v.off;
      data_in      = v.off ? v.flit : '0;
      grant        = v.g;
      stop_in      = v.s;
      if (v.off && v.sb) sbq.push_back(v.flit);
      @(negedge clk);
      got = {request, data_out_valid, forwarding_head,
             forwarding_tail, stop_out};
      exp = {v.er, v.ev, v.eh, v.et, v.ef};
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL vec%0d req/v/h/t/stop got=%b expected=%b",
                  idx, got, exp);
      end
   endtask

   // Scoreboard: every forwarded flit must be the oldest expected one.
   always @(negedge clk) begin
      if (!rst && data_out_valid) begin
         checks++;
         if (sbq.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected got=%h expected=none", data_out);
         end else begin
            logic [33:0] e;
            e = sbq.pop_front();
            if (data_out !== e) begin
               failures++;
               $display("FAIL sb_data got=%h expected=%h", data_out, e);
            end
         end
      end
   end

   initial begin
      logic [33:0] fa, bh, b1, b2, bt;
      logic [33:0] ch, c1, c2, c3, cx, cy, ct;
      logic [33:0] dh, db, dt, dl, eb;
      logic [33:0] rh, r1, r2, r3, rl;

      fa = fl(1, 1, 3, 1, 'h100);
      bh = fl(1, 0, 1, 0, 'h200);
      b1 = fl(0, 0, 0, 0, 'h201);
      b2 = fl(0, 0, 0, 0, 'h202);
      bt = fl(0, 1, 0, 0, 'h203);
      ch = fl(1, 0, 1, 2, 'h300);
      c1 = fl(0, 0, 0, 0, 'h301);
      c2 = fl(0, 0, 0, 0, 'h302);
      c3 = fl(0, 0, 0, 0, 'h303);
      cx = fl(0, 0, 0, 0, 'h3ff);
      cy = fl(0, 0, 0, 0, 'h3fe);
      ct = fl(0, 1, 0, 0, 'h304);
      dh = fl(1, 0, 3, 1, 'h400);
      db = fl(0, 0, 0, 0, 'h401);
      dt = fl(0, 1, 0, 0, 'h402);
      dl = fl(1, 1, 1, 1, 'h500);
      eb = fl(0, 0, 0, 0, 'h600);
      rh = fl(1, 0, 1, 0, 'h700);
      r1 = fl(0, 0, 0, 0, 'h701);
      r2 = fl(0, 0, 0, 0, 'h702);
      r3 = fl(0, 0, 0, 0, 'h703);
      rl = fl(1, 1, 1, 1, 'h800);

      // single head+tail flit east
      tbl[0]  = mv(1, fa, 1, RE, R0, R0, 0, 0, 0, 0);
      tbl[1]  = mv(0, '0, 0, RE, R0, RE, 1, 1, 1, 0);
      tbl[2]  = mv(0, '0, 0, R0, R0, R0, 0, 0, 0, 0);
      // 4-flit packet north, grant withheld 3 cycles
      tbl[3]  = mv(1, bh, 1, R0, R0, R0, 0, 0, 0, 0);
      tbl[4]  = mv(1, b1, 1, R0, R0, RN, 0, 0, 0, 0);
      tbl[5]  = mv(1, b2, 1, R0, R0, RN, 0, 0, 0, 0);
      tbl[6]  = mv(1, bt, 1, R0, R0, RN, 0, 0, 0, 0);
      tbl[7]  = mv(0, '0, 0, RN, R0, RN, 1, 1, 0, 1);
      tbl[8]  = mv(0, '0, 0, RN, R0, RN, 1, 0, 0, 0);
      tbl[9]  = mv(0, '0, 0, RN, R0, RN, 1, 0, 0, 0);
      tbl[10] = mv(0, '0, 0, RN, R0, RN, 1, 0, 1, 0);
      tbl[11] = mv(0, '0, 0, RN, R0, R0, 0, 0, 0, 0);
      // backpressure: fill, drop, refuse push during pop
      tbl[12] = mv(1, ch, 1, R0, R0, R0, 0, 0, 0, 0);
      tbl[13] = mv(1, c1, 1, R0, R0, RS, 0, 0, 0, 0);
      tbl[14] = mv(1, c2, 1, R0, R0, RS, 0, 0, 0, 0);
      tbl[15] = mv(1, c3, 1, R0, R0, RS, 0, 0, 0, 0);
      tbl[16] = mv(1, cx, 0, R0, R0, RS, 0, 0, 0, 1);
      tbl[17] = mv(1, cy, 0, RS, R0, RS, 1, 1, 0, 1);
      tbl[18] = mv(0, '0, 0, R0, R0, RS, 0, 0, 0, 0);
      tbl[19] = mv(0, '0, 0, RS, RS, RS, 0, 0, 0, 0);
      tbl[20] = mv(1, ct, 1, RS, R0, RS, 1, 0, 0, 0);
      tbl[21] = mv(0, '0, 0, RS, R0, RS, 1, 0, 0, 0);
      tbl[22] = mv(0, '0, 0, RS, R0, RS, 1, 0, 0, 0);
      tbl[23] = mv(0, '0, 0, RS, R0, RS, 1, 0, 1, 0);
      // east packet stalled by stop_in[3], local packet queued behind
      tbl[24] = mv(1, dh, 1, R0, R0, R0, 0, 0, 0, 0);
      tbl[25] = mv(1, db, 1, RE, R0, RE, 1, 1, 0, 0);
      tbl[26] = mv(1, dt, 1, RE, RE, RE, 0, 0, 0, 0);
      tbl[27] = mv(1, dl, 1, RE | RL, RE, RE, 0, 0, 0, 0);
      tbl[28] = mv(0, '0, 0, RE | RL, R0, RE, 1, 0, 0, 0);
      tbl[29] = mv(0, '0, 0, RE | RL, R0, RE, 1, 0, 1, 0);
      tbl[30] = mv(0, '0, 0, RE | RL, R0, RL, 1, 1, 1, 0);
      tbl[31] = mv(0, '0, 0, R0, R0, R0, 0, 0, 0, 0);
      // orphan body flit in IDLE
      tbl[32] = mv(1, eb, 0, R0, R0, R0, 0, 0, 0, 0);
      tbl[33] = mv(0, '0, 0, 5'h1f, R0, R0, 0, 0, 0, 0);
      tbl[34] = mv(0, '0, 0, R0, R0, R0, 0, 0, 0, 0);

      #2 rst = 1'b1;
      #2;
      checks++;
      if ({request, data_out_valid, forwarding_head, forwarding_tail,
           stop_out} !== 9'b0 || data_out !== '0) begin
         failures++;
         $display("FAIL reset_outputs got=%b/%h expected=0/0",
                  {request, data_out_valid, forwarding_head,
                   forwarding_tail, stop_out}, data_out);
      end
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 35; i++) step(tbl[i], i);

      // async reset while ACTIVE with 3 flits queued
      step(mv(1, rh, 1, R0, R0, R0, 0, 0, 0, 0), 100);
      step(mv(1, r1, 1, R0, R0, RN, 0, 0, 0, 0), 101);
      step(mv(1, r2, 1, R0, R0, RN, 0, 0, 0, 0), 102);
      step(mv(1, r3, 1, RN, R0, RN, 1, 1, 0, 0), 103);
      @(posedge clk);
      #1;
      data_in_void = 1'b1;
      grant        = RN;
      stop_in      = RN;
      #2;
      checks++;
      if (request !== RN || data_out_valid !== 1'b0) begin
         failures++;
         $display("FAIL active_hold got=%b/%b expected=%b/0",
                  request, data_out_valid, RN);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({request, data_out_valid, forwarding_head, forwarding_tail,
           stop_out} !== 9'b0 || data_out !== '0) begin
         failures++;
         $display("FAIL async_reset got=%b/%h expected=0/0",
                  {request, data_out_valid, forwarding_head,
                   forwarding_tail, stop_out}, data_out);
      end
      sbq.delete();
      @(negedge clk);
      rst     = 1'b0;
      grant   = R0;
      stop_in = R0;
      step(mv(1, rl, 1, RL, R0, R0, 0, 0, 0, 0), 200);
      step(mv(0, '0, 0, RL, R0, RL, 1, 1, 1, 0), 201);
      step(mv(0, '0, 0, R0, R0, R0, 0, 0, 0, 0), 202);

      checks++;
      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover got=%0d expected=0", sbq.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
